// File: rtl/trg_pkg.sv
// trg_pkg: shared FSM encodings, mode constants and default widths for the TRG/ACK engine.
package trg_pkg;
    localparam int N_CH_DEF = 12;
    localparam int PW_W_DEF = 8;
    localparam int TO_W_DEF = 24;
    localparam int SYNC_DEF = 2;

    localparam logic MODE_HS    = 1'b0;
    localparam logic MODE_PULSE = 1'b1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} run_st_e;
    typedef enum logic [1:0] {CH_OFF, CH_REQ, CH_REL, CH_CPL} ch_st_e;
endpackage

// File: rtl/trg_ack_chan.sv
// trg_ack_chan: one TRG/ACK channel - ACK synchroniser, rising-edge detect and the
// four-phase / fixed-pulse channel FSM.
module trg_ack_chan
    import trg_pkg::*;
#(
    parameter int PW_W        = PW_W_DEF,
    parameter int SYNC_STAGES = SYNC_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            en_i,
    input  logic            run_i,
    input  logic            kill_i,
    input  logic            mode_i,
    input  logic [PW_W-1:0] pulse_len_i,
    input  logic            ack_i,
    output logic            trg_o,
    output logic            ack_seen_o,
    output logic            cpl_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q, ack_s, rise;
    ch_st_e                 st_q, st_d;
    logic                   trg_q, trg_d, seen_q, seen_d;
    logic [PW_W-1:0]        cnt_q, cnt_d;

    assign ack_s = sync_q[SYNC_STAGES-1];
    assign rise  = ack_s & ~prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            st_q   <= CH_OFF;
            trg_q  <= 1'b0;
            seen_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ack_i};
            prev_q <= ack_s;
            st_q   <= st_d;
            trg_q  <= trg_d;
            seen_q <= seen_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        trg_d  = trg_q;
        seen_d = seen_q;
        cnt_d  = cnt_q;
        if (start_i) begin
            st_d   = en_i ? CH_REQ : CH_OFF;
            trg_d  = en_i;
            seen_d = 1'b0;
            cnt_d  = (pulse_len_i == '0) ? PW_W'(1) : pulse_len_i;
        end else if (run_i) begin
            // pulse mode takes an ACK edge anywhere in the run, four-phase only while requesting
            if (rise && (mode_i == MODE_PULSE ? st_q != CH_OFF : st_q == CH_REQ))
                seen_d = 1'b1;
            case (st_q)
                CH_REQ: begin
                    if (mode_i == MODE_HS) begin
                        if (rise) begin
                            st_d  = CH_REL;
                            trg_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q - PW_W'(1);
                        if (cnt_q == PW_W'(1)) begin
                            trg_d = 1'b0;
                            st_d  = seen_d ? CH_CPL : CH_REL;
                        end
                    end
                end
                CH_REL:  if (mode_i == MODE_HS ? !ack_s : seen_d) st_d = CH_CPL;
                default: ;
            endcase
            if (kill_i) trg_d = 1'b0;
        end
    end

    // next-state view lets a completion landing on the timeout cycle win the tie
    assign cpl_o      = st_d == CH_CPL;
    assign trg_o      = trg_q;
    assign ack_seen_o = seen_q;
endmodule

// File: rtl/trg_ack_engine.sv
// trg_ack_engine: run FSM, elapsed/timeout tracking and abort handling over N_CH
// TRG/ACK channels in the BOARD_CLOCK domain.
module trg_ack_engine
    import trg_pkg::*;
#(
    parameter int N_CH        = N_CH_DEF,
    parameter int PW_W        = PW_W_DEF,
    parameter int TO_W        = TO_W_DEF,
    parameter int SYNC_STAGES = SYNC_DEF
) (
    input  logic            BOARD_CLOCK,
    input  logic            RST,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [N_CH-1:0] mask_i,
    input  logic            mode_i,
    input  logic [PW_W-1:0] pulse_len_i,
    input  logic [TO_W-1:0] timeout_i,
    input  logic [N_CH-1:0] ack_i,
    output logic [N_CH-1:0] trg_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [N_CH-1:0] ack_seen_o,
    output logic [N_CH-1:0] tmo_o,
    output logic [TO_W-1:0] elapsed_o
);
    run_st_e         st_q, st_d;
    logic [N_CH-1:0] mask_q, tmo_q, cpl;
    logic            mode_q;
    logic [TO_W-1:0] to_q, el_q;
    logic            accept, run, all_done, to_hit, kill;

    assign accept   = st_q == ST_IDLE && start_i;
    assign run      = st_q == ST_RUN;
    assign all_done = &(cpl | ~mask_q);
    assign to_hit   = to_q != '0 && ({1'b0, el_q} + (TO_W+1)'(1)) == {1'b0, to_q};
    // abort beats timeout, completion beats timeout
    assign kill     = run && (abort_i || (to_hit && !all_done));

    always_ff @(posedge BOARD_CLOCK or negedge RST) begin
        if (!RST) st_q <= ST_IDLE;
        else      st_q <= st_d;
    end

    always_comb begin
        st_d = (st_q == ST_IDLE) ? (start_i ? ST_RUN : ST_IDLE) :
               (st_q == ST_RUN)  ? ((abort_i || all_done || to_hit) ? ST_FIN : ST_RUN) :
                                   ST_IDLE;
    end

    always_comb begin
        busy_o = st_q == ST_RUN;
        done_o = st_q == ST_FIN;
    end

    always_ff @(posedge BOARD_CLOCK or negedge RST) begin
        if (!RST) begin
            mask_q <= '0;
            mode_q <= MODE_HS;
            to_q   <= '0;
            el_q   <= '0;
            tmo_q  <= '0;
        end else if (accept) begin
            mask_q <= mask_i;
            mode_q <= mode_i;
            to_q   <= timeout_i;
            el_q   <= '0;
            tmo_q  <= '0;
        end else if (run) begin
            if (~&el_q) el_q <= el_q + TO_W'(1);
            if (kill && !abort_i) tmo_q <= mask_q & ~cpl;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        trg_ack_chan #(
            .PW_W        (PW_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk_i       (BOARD_CLOCK),
            .rst_ni      (RST),
            .start_i     (accept),
            .en_i        (mask_i[i]),
            .run_i       (run),
            .kill_i      (kill),
            .mode_i      (mode_q),
            .pulse_len_i (pulse_len_i),
            .ack_i       (ack_i[i]),
            .trg_o       (trg_o[i]),
            .ack_seen_o  (ack_seen_o[i]),
            .cpl_o       (cpl[i])
        );
    end

    assign tmo_o     = tmo_q;
    assign elapsed_o = el_q;
endmodule

// File: tb/tb_trg_ack_engine.sv
// tb_trg_ack_engine: directed and randomized runs against a cable/ACK responder model.
module tb_trg_ack_engine;
    localparam int N  = 12;
    localparam int PW = 8;
    localparam int TW = 8;
    localparam int SS = 2;

    logic          clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, abort_i = 1'b0, mode_i = 1'b0;
    logic [N-1:0]  mask_i = '0, ack_i = '0, trg_o, ack_seen_o, tmo_o;
    logic [PW-1:0] pulse_len_i = '0;
    logic [TW-1:0] timeout_i = '0, elapsed_o;
    logic          busy_o, done_o;

    int tests = 0, fails = 0, n = 0;
    int done_cnt, done_el, late;
    bit done_seen;
    logic [N-1:0] trg_at_done, en = '0;
    int trg_len[N], hi[N], lo[N], ack_at[N], rdly[N], fdly[N];

    always #5 clk = ~clk;

    trg_ack_engine #(.N_CH(N), .PW_W(PW), .TO_W(TW), .SYNC_STAGES(SS)) dut (
        .BOARD_CLOCK (clk),
        .RST         (rst_n),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .mask_i      (mask_i),
        .mode_i      (mode_i),
        .pulse_len_i (pulse_len_i),
        .timeout_i   (timeout_i),
        .ack_i       (ack_i),
        .trg_o       (trg_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ack_seen_o  (ack_seen_o),
        .tmo_o       (tmo_o),
        .elapsed_o   (elapsed_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, want);
        end
    endtask

    // one cycle: sample at negedge, then let the cable model react
    task automatic cyc();
        @(negedge clk);
        n++;
        if (done_o) begin
            if (!done_seen) begin
                done_el     = int'(elapsed_o);
                trg_at_done = trg_o;
            end
            done_seen = 1'b1;
            done_cnt++;
        end
        for (int i = 0; i < N; i++) begin
            if (trg_o[i]) trg_len[i]++;
            if (trg_o[i] && mode_i == 1'b0 && ack_at[i] >= 0 && n - ack_at[i] >= SS + 1) late++;
            if (en[i]) begin
                if (trg_o[i]) begin
                    lo[i] = 0;
                    hi[i]++;
                    if (hi[i] == rdly[i] && !ack_i[i]) begin
                        ack_i[i]  = 1'b1;
                        ack_at[i] = n;
                    end
                end else begin
                    hi[i] = 0;
                    if (ack_i[i]) begin
                        lo[i]++;
                        if (lo[i] == fdly[i]) ack_i[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic clear_run();
        done_cnt = 0; done_seen = 1'b0; done_el = -1; trg_at_done = '1; late = 0;
        for (int i = 0; i < N; i++) begin
            trg_len[i] = 0; hi[i] = 0; lo[i] = 0; ack_at[i] = -1;
        end
    endtask

    task automatic run(input logic [N-1:0] m, input logic md, input int pl, input int to,
                       input int ab_el, input int budget);
        clear_run();
        mask_i = m; mode_i = md; pulse_len_i = PW'(pl); timeout_i = TW'(to);
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        for (int c = 0; c < budget && !done_seen; c++) begin
            abort_i = (c == ab_el);
            cyc();
        end
        abort_i = 1'b0;
        chk("done_reached", done_seen, 1);
        repeat (12) cyc();
    endtask

    task automatic set_resp(input logic [N-1:0] e, input int rd, input int fd);
        en = e;
        for (int i = 0; i < N; i++) begin
            rdly[i] = rd; fdly[i] = fd;
        end
    endtask

    initial begin
        logic [N-1:0] m;
        int to, w, bad, el_before, t_cal;
        bit silent;

        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        chk("rst_trg", trg_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_seen", ack_seen_o, 0);
        chk("rst_tmo", tmo_o, 0);
        chk("rst_elapsed", elapsed_o, 0);

        abort_i = 1'b1;
        cyc();
        abort_i = 1'b0;
        cyc();
        chk("idle_abort_busy", busy_o, 0);
        chk("idle_abort_done", done_o, 0);

        // four-phase, every channel answers
        set_resp('1, 5, 4);
        run(12'hFFF, 1'b0, 0, 0, -1, 400);
        chk("hs_seen", ack_seen_o, 12'hFFF);
        chk("hs_tmo", tmo_o, 0);
        chk("hs_done_cnt", done_cnt, 1);
        chk("hs_trg_end", trg_o, 0);
        chk("hs_trg_release", late, 0);
        chk("hs_busy_end", busy_o, 0);

        // timeout with channel 2 silent
        set_resp(12'hFFB, 5, 4);
        run(12'h00F, 1'b0, 0, 100, -1, 400);
        chk("to_elapsed", done_el, 100);
        chk("to_tmo", tmo_o, 12'h004);
        chk("to_seen", ack_seen_o, 12'h00B);
        chk("to_trg_at_done", trg_at_done, 0);
        chk("to_done_cnt", done_cnt, 1);

        // pulse mode, width 10 then width 0 (treated as 1)
        set_resp('1, 3, 2);
        run(12'h001, 1'b1, 10, 0, -1, 400);
        chk("p10_width", trg_len[0], 10);
        chk("p10_seen", ack_seen_o, 12'h001);
        chk("p10_trg_at_done", trg_at_done, 0);
        chk("p10_done_cnt", done_cnt, 1);
        set_resp('1, 1, 2);
        run(12'h001, 1'b1, 0, 0, -1, 400);
        chk("p0_width", trg_len[0], 1);
        chk("p0_seen", ack_seen_o, 12'h001);

        // empty mask: done two cycles after start, trg untouched
        run(12'h000, 1'b0, 0, 0, -1, 20);
        chk("m0_elapsed", done_el, 1);
        bad = 0;
        for (int i = 0; i < N; i++) bad += trg_len[i];
        chk("m0_trg_quiet", bad, 0);

        // stale ACK and start while busy
        set_resp('0, 1, 1);
        clear_run();
        ack_i[1] = 1'b1;
        repeat (4) cyc();
        mask_i = 12'h002; mode_i = 1'b0; timeout_i = '0;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        repeat (6) cyc();
        chk("stale_held", ack_seen_o, 0);
        ack_i[1] = 1'b0;
        repeat (4) cyc();
        chk("stale_low", ack_seen_o, 0);
        ack_i[1] = 1'b1;
        repeat (4) cyc();
        chk("stale_rerise", ack_seen_o, 12'h002);
        chk("stale_trg_low", trg_o, 0);
        el_before = int'(elapsed_o);
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        chk("busy_start_el", elapsed_o, el_before + 1);
        chk("busy_start_seen", ack_seen_o, 12'h002);
        chk("busy_start_busy", busy_o, 1);
        ack_i[1] = 1'b0;
        for (int c = 0; c < 40 && !done_seen; c++) cyc();
        chk("stale_done", done_seen, 1);
        repeat (4) cyc();
        chk("stale_done_cnt", done_cnt, 1);
        chk("stale_tmo", tmo_o, 0);

        // abort at cycle 20
        set_resp('0, 1, 1);
        run(12'hFFF, 1'b0, 0, 0, 20, 400);
        chk("ab_elapsed", done_el, 21);
        chk("ab_trg_at_done", trg_at_done, 0);
        chk("ab_tmo", tmo_o, 0);
        chk("ab_done_cnt", done_cnt, 1);

        // abort and timeout in the same cycle
        run(12'h0F0, 1'b0, 0, 50, 49, 400);
        chk("abto_tmo", tmo_o, 0);
        chk("abto_elapsed", done_el, 50);

        // elapsed saturates at all-ones
        run(12'h001, 1'b0, 0, 0, 300, 400);
        chk("sat_elapsed", done_el, 255);
        chk("sat_trg_at_done", trg_at_done, 0);

        // completion/timeout tie: measure the completion point, then aim the timeout at it
        set_resp('1, 5, 4);
        run(12'h001, 1'b0, 0, 0, -1, 400);
        t_cal = done_el;
        run(12'h001, 1'b0, 0, t_cal, -1, 400);
        chk("tie_tmo", tmo_o, 0);
        chk("tie_done_cnt", done_cnt, 1);
        chk("tie_elapsed", done_el, t_cal);
        run(12'h001, 1'b0, 0, t_cal - 1, -1, 400);
        chk("early_to_tmo", tmo_o, 12'h001);
        chk("early_to_elapsed", done_el, t_cal - 1);

        // randomized runs, alternating modes
        for (int k = 0; k < 10; k++) begin
            m = N'($urandom_range(1, 4095));
            w = $urandom_range(0, 20);
            silent = 1'b0;
            for (int i = 0; i < N; i++) begin
                en[i]   = $urandom_range(0, 5) != 0;
                rdly[i] = (k % 2 == 1) ? $urandom_range(1, (w == 0) ? 1 : w) : $urandom_range(1, 8);
                fdly[i] = $urandom_range(1, 8);
                if (m[i] && !en[i]) silent = 1'b1;
            end
            to = (silent || $urandom_range(0, 1) == 1) ? $urandom_range(60, 150) : 0;
            run(m, 1'(k % 2), w, to, -1, 400);
            chk("rnd_seen", ack_seen_o, m & en);
            chk("rnd_tmo", tmo_o, silent ? (m & ~en) : '0);
            chk("rnd_done_cnt", done_cnt, 1);
            chk("rnd_trg_at_done", trg_at_done, 0);
            if (silent) chk("rnd_to_elapsed", done_el, to);
            if (k % 2 == 1) begin
                bad = 0;
                for (int i = 0; i < N; i++)
                    if (trg_len[i] != (m[i] ? ((w == 0) ? 1 : w) : 0)) bad++;
                chk("rnd_pulse_width", bad, 0);
            end else begin
                chk("rnd_trg_release", late, 0);
            end
        end

        // reset mid-run
        set_resp('0, 1, 1);
        clear_run();
        mask_i = 12'hFFF; mode_i = 1'b0; timeout_i = '0;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        repeat (8) cyc();
        chk("mid_trg_pre", trg_o, 12'hFFF);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_trg", trg_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_done", done_o, 0);
        chk("mid_rst_elapsed", elapsed_o, 0);
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        chk("mid_rst_no_done", done_cnt, 0);
        chk("mid_rst_idle", busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/trg_ack_engine.md
Name: trg_ack_engine

Overview:
- Parametrised successor to the fixed 12-bit TRG/ACK register path. Drives N_CH trigger lines to front-end boards and tracks their ACK returns.
- Two modes per run:
  - Four-phase handshake: TRG high, then ACK high, then TRG low, then ACK low.
  - Fixed-width pulse: TRG held for a set width; ACK rising edges are recorded.
- Adds per-channel timeout, abort and completion status.
- Sits between the wishbone slave register file and the TRG/ACK pins, in the BOARD_CLOCK domain.

Parameters:
- N_CH, 12, number of trigger/acknowledge channels
- PW_W, 8, width of the pulse-length field
- TO_W, 24, width of the timeout and elapsed counters
- SYNC_STAGES, 2, synchroniser depth on ACK inputs (minimum 2)

Ports:
- BOARD_CLOCK, in, 1, sole clock
- RST, in, 1, asynchronous active-low reset
- start_i, in, 1, single-cycle run request
- abort_i, in, 1, single-cycle abort request
- mask_i, in, N_CH, channels taking part; sampled on accepted start
- mode_i, in, 1, 0 = four-phase, 1 = pulse; sampled on accepted start
- pulse_len_i, in, PW_W, TRG width in cycles for pulse mode; 0 is treated as 1
- timeout_i, in, TO_W, run timeout in cycles; 0 disables the timeout
- ack_i, in, N_CH, asynchronous ACK lines from the cable
- trg_o, out, N_CH, registered TRG lines
- busy_o, out, 1, high from accepted start until done
- done_o, out, 1, one-cycle pulse at run end
- ack_seen_o, out, N_CH, channels whose ACK rising edge was captured this run
- tmo_o, out, N_CH, channels unfinished at timeout
- elapsed_o, out, TO_W, cycles since start; saturating; held after done

Behaviour:
- Reset:
  - All outputs are 0; FSM is in IDLE; synchronisers are cleared.
  - Reset asserted mid-run drops trg_o immediately (asynchronous). No done_o pulse is produced.
- ACK path:
  - SYNC_STAGES flops, then one edge-detect register.
  - Rising edge = synced value high while previous synced value is low.
  - An ACK already high at start does not count; it must fall and rise again.
- Top FSM states: IDLE, RUN, FIN.
  - IDLE:
    - start_i accepted only here; start_i during RUN/FIN is ignored.
    - On accept: latch mask/mode/pulse_len/timeout; clear ack_seen_o, tmo_o, elapsed_o; go to RUN.
    - trg_o for masked channels rises the cycle after start_i.
    - mask = 0: go straight to FIN; done_o pulses 2 cycles after start; trg_o never toggles.
  - RUN:
    - elapsed_o increments each cycle and saturates at all-ones.
    - Leaves for FIN when all masked channels are complete, on timeout, or on abort.
  - FIN: done_o = 1 for one cycle, busy_o = 0, then back to IDLE. Status outputs hold until the next accepted start.
- Per-channel states: CH_OFF, CH_REQ, CH_REL, CH_CPL.
  - Four-phase mode:
    - CH_REQ: TRG high; on ACK rising edge set ack_seen and go to CH_REL.
    - CH_REL: TRG low (low by 3 + SYNC_STAGES − 2 cycles after ack_i rise); go to CH_CPL when synced ACK is low.
  - Pulse mode:
    - TRG is high for exactly max(pulse_len, 1) cycles.
    - An ACK rising edge is captured at any point in RUN.
    - Channel is CH_CPL once TRG is released and ack_seen is set.
- Timeout:
  - Fires in the cycle where elapsed_o + 1 == timeout_i (timeout_i ≠ 0).
  - Unfinished masked channels get their tmo_o bit set; all trg_o drop next cycle; go to FIN.
  - If the last completion and the timeout fall in the same cycle, completion wins and tmo_o stays 0.
- Abort:
  - All trg_o drop next cycle; go to FIN; tmo_o is not set.
  - If abort and timeout coincide, abort wins.
  - abort_i in IDLE has no effect.
- Channel mapping: trg_o[i] is paired only with ack_i[i]; channels are independent except for the shared run end.

Decomposition:
- Shared package (trg_pkg): FSM state encodings (top and channel), MODE_HS / MODE_PULSE constants, default widths.
- One sub-module, trg_ack_chan: the per-channel FSM, synchroniser and edge detector. Instantiated N_CH times with a generate loop.
- The top module holds the run FSM, elapsed counter and timeout compare.

Test Plan:
- Four-phase, all channels answer:
  - Stimulus: N_CH=12, mask=0xFFF, mode=0, timeout=0; bench ACK model raises ACK 5 cycles after TRG and drops it 4 cycles after TRG falls.
  - Required: ack_seen_o=0xFFF, tmo_o=0, one done_o pulse, trg_o=0 at the end.
- Timeout, one silent channel:
  - Stimulus: mask=0x00F, channel 2 never ACKs, timeout=100.
  - Required: done_o at elapsed=100; tmo_o=0x004; ack_seen_o=0x00B; trg_o[2] low after the timeout.
- Pulse mode:
  - Stimulus: pulse_len=10, mask=0x001, ACK rises at cycle 3 after start.
  - Required: trg_o[0] high for exactly 10 cycles; done_o after release; ack_seen_o=0x001.
  - Repeat with pulse_len=0: TRG pulse is 1 cycle wide.
- Stale ACK and start-while-busy:
  - Stimulus: ack_i[1] held high before start, mask=0x002.
  - Required: no ack_seen until ACK drops and rises again. A second start_i during RUN changes nothing.
- Abort and reset mid-run:
  - abort at cycle 20 -> trg_o=0 next cycle, done_o pulses, tmo_o=0.
  - RST low mid-run -> all outputs 0 immediately, no done_o.
- Completion/timeout tie:
  - Stimulus: the last ACK completion lands in the cycle where elapsed_o + 1 == timeout_i.
  - Required: tmo_o=0, done_o pulses once.
